stb_dcache_port_arbiter: RTL

//  Shares the single dcache request port between the LSU load path and the store buffer drain path.

---
 rtl/stb_dcache_port_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/stb_dcache_port_arbiter.sv
// stb_dcache_port_arbiter: shares the single dcache port between LSU loads and store-buffer drains, sequencing fences
// Ports: lsummu2arb_* load address/request and fence request; arb2lsummu_* load data, load ack, fence ack;
//        stb2arb_* store-buffer head entry, request, empty/full status; arb2stb_ack head-entry drained;
//        arb2dcache_* registered dcache request bus; dcache2arb_* dcache read data and completion.
module stb_dcache_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SEL_WIDTH = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     lsummu2arb_addr,
  input  logic                      lsummu2arb_req,
  input  logic                      lsummu2arb_fence_req,
  output logic [DATA_WIDTH-1:0]     arb2lsummu_rdata,
  output logic                      arb2lsummu_ack,
  output logic                      arb2lsummu_fence_ack,
  input  logic [ADDR_WIDTH-1:0]     stb2arb_addr,
  input  logic [DATA_WIDTH-1:0]     stb2arb_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] stb2arb_sel_byte,
  input  logic                      stb2arb_w_en,
  input  logic                      stb2arb_req,
  input  logic                      stb2arb_empty,
  input  logic                      stb2arb_full,
  output logic                      arb2stb_ack,
  output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
  output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
  output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
  output logic                      arb2dcache_w_en,
  output logic                      arb2dcache_req,
  input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata,
  input  logic                      dcache2arb_ack
);
  typedef enum logic [1:0] {IDLE, LOAD_BUSY, STORE_BUSY} state_t;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  state_t state, state_nx;
  logic [CW-1:0] starve_cnt;
  logic grant_ok, starved, word_eq, pick_store, pick_load, fence_fire, done;
  always_comb begin
    // while an ack pulse is out, the acked requester still presents its finished request
    grant_ok = state == IDLE && !arb2lsummu_ack && !arb2stb_ack && !arb2lsummu_fence_ack;
    starved = starve_cnt == LIMIT;
    word_eq = lsummu2arb_addr[ADDR_WIDTH-1:2] == stb2arb_addr[ADDR_WIDTH-1:2];
    // store wins on fence, full, starvation, same-word hazard, or when no load competes
    pick_store = grant_ok && stb2arb_req &&
                 (lsummu2arb_fence_req || stb2arb_full || starved || word_eq || !lsummu2arb_req);
    pick_load = grant_ok && lsummu2arb_req && !lsummu2arb_fence_req && !pick_store;
    fence_fire = grant_ok && lsummu2arb_fence_req && stb2arb_empty && !stb2arb_req;
    done = state != IDLE && dcache2arb_ack;
    state_nx = pick_store ? STORE_BUSY : pick_load ? LOAD_BUSY : done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      arb2lsummu_rdata <= '0;
      arb2lsummu_ack <= 1'b0;
      arb2lsummu_fence_ack <= 1'b0;
      arb2stb_ack <= 1'b0;
      arb2dcache_addr <= '0;
      arb2dcache_wdata <= '0;
      arb2dcache_sel_byte <= '0;
      arb2dcache_w_en <= 1'b0;
      arb2dcache_req <= 1'b0;
    end else begin
      arb2lsummu_ack <= done && state == LOAD_BUSY;
      arb2stb_ack <= done && state == STORE_BUSY;
      arb2lsummu_fence_ack <= fence_fire;
      if (done && state == LOAD_BUSY) arb2lsummu_rdata <= dcache2arb_rdata;
      if (pick_store || pick_load) begin
        arb2dcache_req <= 1'b1;
        arb2dcache_addr <= pick_store ? stb2arb_addr : lsummu2arb_addr;
        arb2dcache_wdata <= pick_store ? stb2arb_wdata : '0;
        arb2dcache_sel_byte <= pick_store ? stb2arb_sel_byte : '1;
        arb2dcache_w_en <= pick_store ? stb2arb_w_en : 1'b0;
      end else if (done) begin
        arb2dcache_req <= 1'b0;
      end
      if (pick_store) starve_cnt <= '0;
      else if (pick_load && stb2arb_req && !starved) starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule
